// File: rtl/uart_fw_loader.sv
// Serial firmware boot loader: decodes 8N1 UART frames and writes program memory.
// Ports: clk, resetn, ser_rx in; progmem_wen/waddr/wdata, cpu_resetn, load_busy/done/err out.
module uart_fw_loader #(
    parameter int unsigned CLK_DIV     = 217,
    parameter logic [31:0] BASE_ADDR   = 32'h0010_0000,
    parameter int unsigned MAX_WORDS   = 8192,
    parameter int unsigned TIMEOUT_CYC = 2_500_000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ser_rx,
    output logic        progmem_wen,
    output logic [31:0] progmem_waddr,
    output logic [31:0] progmem_wdata,
    output logic        cpu_resetn,
    output logic        load_busy,
    output logic        load_done,
    output logic        load_err
);

    localparam logic [15:0] BIT_LAST = 16'(CLK_DIV - 1);
    localparam logic [15:0] BIT_HALF = 16'(CLK_DIV / 2 - 1);
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYC - 1);
    localparam logic [31:0] MAX_LEN  = 32'(MAX_WORDS);

    typedef enum logic [1:0] {
        RX_IDLE, RX_START, RX_DATA, RX_STOP
    } rx_state_t;

    typedef enum logic [2:0] {
        SYNC0, SYNC1, LEN0, LEN1, DATA, CSUM, DONE, ERR
    } state_t;

    // receiver
    logic        rx_s1_q, rx_s2_q, rx_prev_q;
    rx_state_t   rx_state_q, rx_state_d;
    logic [15:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_sh_q, rx_sh_d;
    logic [7:0]  rx_byte_q, rx_byte_d;
    logic        rx_valid_q, rx_valid_d;
    logic        rx_ferr_q, rx_ferr_d;

    // loader
    state_t      state_q, state_d;
    logic [15:0] len_q, len_d;
    logic [15:0] idx_q, idx_d;
    logic [7:0]  csum_q, csum_d;
    logic [1:0]  bcnt_q, bcnt_d;
    logic [31:0] word_q, word_d;
    logic [31:0] tmo_q, tmo_d;
    logic        wen_q, wen_d;
    logic [31:0] waddr_q, waddr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        cpu_q, cpu_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic        tmo_hit;
    logic [31:0] word_nx;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_sh_q    <= '0;
            rx_byte_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_ferr_q  <= 1'b0;
        end else begin
            rx_s1_q    <= ser_rx;
            rx_s2_q    <= rx_s1_q;
            rx_prev_q  <= rx_s2_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_sh_q    <= rx_sh_d;
            rx_byte_q  <= rx_byte_d;
            rx_valid_q <= rx_valid_d;
            rx_ferr_q  <= rx_ferr_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_sh_d    = rx_sh_q;
        rx_byte_d  = rx_byte_q;
        rx_valid_d = 1'b0;
        rx_ferr_d  = 1'b0;
        unique case (rx_state_q)
            RX_IDLE: begin
                if (rx_prev_q && !rx_s2_q) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = '0;
                end
            end
            RX_START: begin
                if (rx_cnt_q == BIT_HALF) begin
                    // line back high at mid start bit: a glitch
                    if (rx_s2_q) begin
                        rx_state_d = RX_IDLE;
                    end else begin
                        rx_state_d = RX_DATA;
                        rx_cnt_d   = '0;
                        rx_bit_d   = '0;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 16'd1;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
                    rx_cnt_d = '0;
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 3'd1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 16'd1;
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_state_d = RX_IDLE;
                    if (rx_s2_q) begin
                        rx_valid_d = 1'b1;
                        rx_byte_d  = rx_sh_q;
                    end else begin
                        rx_ferr_d = 1'b1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 16'd1;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= SYNC0;
            len_q   <= '0;
            idx_q   <= '0;
            csum_q  <= '0;
            bcnt_q  <= '0;
            word_q  <= '0;
            tmo_q   <= '0;
            wen_q   <= 1'b0;
            waddr_q <= BASE_ADDR;
            wdata_q <= '0;
            cpu_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            csum_q  <= csum_d;
            bcnt_q  <= bcnt_d;
            word_q  <= word_d;
            tmo_q   <= tmo_d;
            wen_q   <= wen_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            cpu_q   <= cpu_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign tmo_hit = (tmo_q == TMO_LAST) && !rx_valid_q;
    assign word_nx = {rx_byte_q, word_q[31:8]};

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        csum_d  = csum_q;
        bcnt_d  = bcnt_q;
        word_d  = word_q;
        wen_d   = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        cpu_d   = cpu_q;
        busy_d  = busy_q;
        done_d  = done_q;
        err_d   = err_q;
        tmo_d   = (state_q == SYNC0 || rx_valid_q) ? 32'd0 : tmo_q + 32'd1;
        unique case (state_q)
            SYNC0: begin
                if (rx_valid_q && rx_byte_q == 8'h55) state_d = SYNC1;
            end
            SYNC1: begin
                if (rx_valid_q) begin
                    if (rx_byte_q == 8'hAA) begin
                        state_d = LEN0;
                        cpu_d   = 1'b0;
                        busy_d  = 1'b1;
                        done_d  = 1'b0;
                        err_d   = 1'b0;
                        idx_d   = '0;
                        csum_d  = '0;
                        bcnt_d  = '0;
                    end else if (rx_byte_q != 8'h55) begin
                        state_d = SYNC0;
                    end
                end else if (tmo_hit) begin
                    state_d = SYNC0;
                end
            end
            LEN0: begin
                if (rx_valid_q) begin
                    len_d   = {len_q[15:8], rx_byte_q};
                    state_d = LEN1;
                end else if (rx_ferr_q || tmo_hit) begin
                    state_d = ERR;
                end
            end
            LEN1: begin
                if (rx_valid_q) begin
                    len_d = {rx_byte_q, len_q[7:0]};
                    if ({16'd0, len_d} > MAX_LEN) state_d = ERR;
                    else if (len_d == 16'd0)      state_d = CSUM;
                    else                          state_d = DATA;
                end else if (rx_ferr_q || tmo_hit) begin
                    state_d = ERR;
                end
            end
            DATA: begin
                if (rx_valid_q) begin
                    word_d = word_nx;
                    csum_d = csum_q + rx_byte_q;
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        wen_d   = 1'b1;
                        waddr_d = BASE_ADDR + {14'd0, idx_q, 2'b00};
                        wdata_d = word_nx;
                        idx_d   = idx_q + 16'd1;
                        if (idx_q == len_q - 16'd1) state_d = CSUM;
                    end
                end else if (rx_ferr_q || tmo_hit) begin
                    state_d = ERR;
                end
            end
            CSUM: begin
                if (rx_valid_q) begin
                    state_d = (rx_byte_q == csum_q) ? DONE : ERR;
                end else if (rx_ferr_q || tmo_hit) begin
                    state_d = ERR;
                end
            end
            DONE: begin
                cpu_d   = 1'b1;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = SYNC0;
            end
            ERR: begin
                // cpu stays in reset: a partial image must not run
                busy_d  = 1'b0;
                err_d   = 1'b1;
                state_d = SYNC0;
            end
            default: state_d = SYNC0;
        endcase
    end

    assign progmem_wen   = wen_q;
    assign progmem_waddr = waddr_q;
    assign progmem_wdata = wdata_q;
    assign cpu_resetn    = cpu_q;
    assign load_busy     = busy_q;
    assign load_done     = done_q;
    assign load_err      = err_q;

endmodule

// File: tb/tb_uart_fw_loader.sv
// Bench for uart_fw_loader: frame table plus hand-written corner sequences.
// Expected program-memory writes go through a queue checked on every strobe.
module tb_uart_fw_loader;

    localparam int DIV = 8;
    localparam logic [31:0] BASE = 32'h0010_0000;

    logic        clk;
    logic        resetn;
    logic        ser_rx;
    logic        progmem_wen;
    logic [31:0] progmem_waddr;
    logic [31:0] progmem_wdata;
    logic        cpu_resetn;
    logic        load_busy;
    logic        load_done;
    logic        load_err;

    int checks = 0;
    int errors = 0;

    uart_fw_loader #(
        .CLK_DIV(DIV),
        .BASE_ADDR(BASE),
        .MAX_WORDS(4),
        .TIMEOUT_CYC(2000)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .ser_rx(ser_rx),
        .progmem_wen(progmem_wen),
        .progmem_waddr(progmem_waddr),
        .progmem_wdata(progmem_wdata),
        .cpu_resetn(cpu_resetn),
        .load_busy(load_busy),
        .load_done(load_done),
        .load_err(load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;
    wr_t wq[$];

    typedef struct {
        string       name;
        int          n;
        logic [7:0]  b [16];
        int          sync_at;
        logic        done;
        logic        err;
        logic        cpu;
        int          nw;
        logic [31:0] w [2];
    } vec_t;
    vec_t v [6];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (resetn && progmem_wen) begin
            if (wq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wen_unexpected got=%h/%h want=none",
                         progmem_waddr, progmem_wdata);
            end else begin
                wr_t e;
                e = wq.pop_front();
                chk("wen_addr", progmem_waddr, e.a);
                chk("wen_data", progmem_wdata, e.d);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(posedge clk);
        ser_rx = 1'b0;
        repeat (DIV) @(posedge clk);
        for (int k = 0; k < 8; k++) begin
            ser_rx = b[k];
            repeat (DIV) @(posedge clk);
        end
        ser_rx = stop;
        repeat (DIV) @(posedge clk);
        ser_rx = 1'b1;
        repeat (4) @(posedge clk);
    endtask

    task automatic push_wr(input int i, input logic [31:0] d);
        wr_t e;
        e.a = BASE + 32'(4 * i);
        e.d = d;
        wq.push_back(e);
    endtask

    task automatic settle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_status(input string tag, input logic done,
                              input logic err, input logic cpu);
        chk({tag, "_done"}, 32'(load_done), 32'(done));
        chk({tag, "_err"}, 32'(load_err), 32'(err));
        chk({tag, "_cpu"}, 32'(cpu_resetn), 32'(cpu));
        chk({tag, "_busy"}, 32'(load_busy), 32'd0);
        chk({tag, "_wq"}, 32'(wq.size()), 32'd0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

    initial begin
        // payload sum 0x114 + 0x338 = 0x44C, so the good checksum is 0x4C
        v[0] = '{"good", 13, '{8'h55, 8'hAA, 8'h02, 8'h00, 8'h78, 8'h56,
                 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h4C, 0, 0, 0},
                 1, 1'b1, 1'b0, 1'b1, 2, '{32'h1234_5678, 32'hDEAD_BEEF}};
        v[1] = '{"badcsum", 13, '{8'h55, 8'hAA, 8'h02, 8'h00, 8'h78, 8'h56,
                 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h4D, 0, 0, 0},
                 1, 1'b0, 1'b1, 1'b0, 2, '{32'h1234_5678, 32'hDEAD_BEEF}};
        v[2] = v[0];
        v[2].name = "resend";
        v[3] = '{"toolong", 4, '{8'h55, 8'hAA, 8'h05, 8'h00, 0, 0, 0, 0,
                 0, 0, 0, 0, 0, 0, 0, 0},
                 1, 1'b0, 1'b1, 1'b0, 0, '{32'h0, 32'h0}};
        v[4] = '{"zerolen", 5, '{8'h55, 8'hAA, 8'h00, 8'h00, 8'h00, 0, 0, 0,
                 0, 0, 0, 0, 0, 0, 0, 0},
                 1, 1'b1, 1'b0, 1'b1, 0, '{32'h0, 32'h0}};
        v[5] = '{"noise", 11, '{8'h13, 8'h55, 8'h55, 8'hAA, 8'h01, 8'h00,
                 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 0, 0, 0, 0, 0},
                 3, 1'b1, 1'b0, 1'b1, 1, '{32'h4433_2211, 32'h0}};

        resetn = 1'b0;
        ser_rx = 1'b1;
        settle(5);
        chk("rst_wen", 32'(progmem_wen), 32'd0);
        chk("rst_waddr", progmem_waddr, BASE);
        chk("rst_wdata", progmem_wdata, 32'd0);
        chk("rst_cpu", 32'(cpu_resetn), 32'd1);
        chk("rst_busy", 32'(load_busy), 32'd0);
        chk("rst_done", 32'(load_done), 32'd0);
        chk("rst_err", 32'(load_err), 32'd0);
        resetn = 1'b1;
        settle(5);

        for (int i = 0; i < 6; i++) begin
            for (int w = 0; w < v[i].nw; w++) push_wr(w, v[i].w[w]);
            for (int j = 0; j < v[i].n; j++) begin
                send_byte(v[i].b[j], 1'b1);
                if (j == v[i].sync_at) begin
                    #1;
                    chk({v[i].name, "_syncbusy"}, 32'(load_busy), 32'd1);
                    chk({v[i].name, "_synccpu"}, 32'(cpu_resetn), 32'd0);
                end
            end
            settle(20);
            chk_status(v[i].name, v[i].done, v[i].err, v[i].cpu);
        end

        // short low glitch between sync bytes must not decode as a byte
        push_wr(0, 32'h4433_2211);
        send_byte(8'h55, 1'b1);
        @(posedge clk);
        ser_rx = 1'b0;
        repeat (2) @(posedge clk);
        ser_rx = 1'b1;
        settle(30);
        send_byte(8'hAA, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        send_byte(8'h44, 1'b1);
        send_byte(8'hAA, 1'b1);
        settle(20);
        chk_status("glitch", 1'b1, 1'b0, 1'b1);

        // stall mid-word until the inter-byte timeout fires
        send_byte(8'h55, 1'b1);
        send_byte(8'hAA, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        settle(1900);
        chk("tmo_busy_before", 32'(load_busy), 32'd1);
        settle(200);
        chk_status("timeout", 1'b0, 1'b1, 1'b0);

        // stop bit low inside the payload
        send_byte(8'h55, 1'b1);
        send_byte(8'hAA, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b0);
        settle(10);
        chk_status("framing", 1'b0, 1'b1, 1'b0);

        // async reset in the middle of the second word
        push_wr(0, 32'h1234_5678);
        for (int j = 0; j < 9; j++) send_byte(v[0].b[j], 1'b1);
        settle(3);
        chk("mid_wq", 32'(wq.size()), 32'd0);
        #2;
        resetn = 1'b0;
        #1;
        chk("mid_wen", 32'(progmem_wen), 32'd0);
        chk("mid_waddr", progmem_waddr, BASE);
        chk("mid_wdata", progmem_wdata, 32'd0);
        chk("mid_cpu", 32'(cpu_resetn), 32'd1);
        chk("mid_busy", 32'(load_busy), 32'd0);
        chk("mid_done", 32'(load_done), 32'd0);
        chk("mid_err", 32'(load_err), 32'd0);
        settle(3);
        resetn = 1'b1;
        settle(3);

        push_wr(0, 32'h1234_5678);
        push_wr(1, 32'hDEAD_BEEF);
        for (int j = 0; j < 13; j++) send_byte(v[0].b[j], 1'b1);
        settle(20);
        chk_status("after_rst", 1'b1, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
